// File: rtl/featuremap_pad_fifo_writer.sv
// Writes one channel's unpadded featuremap into its line-buffer FIFO as a
// zero-bordered (WIDTH+2) x (HEIGHT+2) frame, stalling the source on FIFO back-pressure.
module featuremap_pad_fifo_writer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 56,
  parameter int unsigned HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  fifo_full,
  output logic                  wrreq,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int unsigned COL_W = $clog2(WIDTH + 2);
  localparam int unsigned ROW_W = $clog2(HEIGHT + 2);

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH + 1);
  localparam logic [COL_W-1:0] COL_DATA_LAST = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_DATA_LAST = ROW_W'(HEIGHT);
  localparam logic [ROW_W-1:0] ROW_BOTTOM    = ROW_W'(HEIGHT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOP,
    S_LEFT,
    S_DATA,
    S_RIGHT,
    S_BOTTOM
  } state_t;

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    wrreq_d;
  logic                    frame_done_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    step;

  // Source is only taken while a data column is being written and the FIFO has room.
  assign ready_in = (state_q == S_DATA) && !fifo_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      wrreq      <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wrreq      <= wrreq_d;
      data_out   <= data_d;
      frame_done <= frame_done_d;
    end
  end

  // One word per step; pad states emit zero, DATA forwards the accepted pixel.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    wrreq_d      = 1'b0;
    frame_done_d = 1'b0;
    data_d       = data_out;
    step         = (state_q == S_DATA) ? (valid_in && ready_in)
                                       : ((state_q != S_IDLE) && !fifo_full);
    if (step) begin
      wrreq_d = 1'b1;
      data_d  = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          state_d = S_TOP;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_TOP: begin
        if (step) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = ROW_W'(1);
            state_d = S_LEFT;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_LEFT: begin
        if (step) begin
          col_d   = COL_W'(1);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (step) begin
          data_d = data_in;
          col_d  = col_q + COL_W'(1);
          if (col_q == COL_DATA_LAST) state_d = S_RIGHT;
        end
      end
      S_RIGHT: begin
        if (step) begin
          col_d = '0;
          if (row_q == ROW_DATA_LAST) begin
            row_d   = ROW_BOTTOM;
            state_d = S_BOTTOM;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = S_LEFT;
          end
        end
      end
      S_BOTTOM: begin
        if (step) begin
          if (col_q == COL_LAST) begin
            frame_done_d = 1'b1;
            col_d        = '0;
            row_d        = '0;
            // Chain straight into the next frame when the source already has data.
            state_d      = valid_in ? S_TOP : S_IDLE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_featuremap_pad_fifo_writer.sv
// Randomized bench for featuremap_pad_fifo_writer: a 2x2 instance for the directed
// scenarios and a 56x56 instance under random valid/back-pressure, both checked against a padded-frame model.
module tb_featuremap_pad_fifo_writer;

  localparam int unsigned DW = 32;
  localparam int SW = 2;
  localparam int SH = 2;
  localparam int BW = 56;
  localparam int BH = 56;

  typedef logic [DW-1:0] word_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] s_din, s_dout, b_din, b_dout;
  logic          s_vin, s_rdy, s_full, s_wr, s_fd;
  logic          b_vin, b_rdy, b_full, b_wr, b_fd;

  int      s_mode, b_mode;
  int      tests = 0;
  int      fails = 0;
  int      cyc = 0;
  int      s_rdy_cnt = 0;
  logic    s_prev_full = 1'b0;
  logic    b_prev_full = 1'b0;
  word_q_t s_wq, b_wq;
  int      s_fdq[$], b_fdq[$], s_wcyc[$];

  featuremap_pad_fifo_writer #(.DATA_WIDTH(DW), .WIDTH(SW), .HEIGHT(SH)) u_small (
    .clk(clk), .rst(rst), .data_in(s_din), .valid_in(s_vin), .ready_in(s_rdy),
    .fifo_full(s_full), .wrreq(s_wr), .data_out(s_dout), .frame_done(s_fd)
  );

  featuremap_pad_fifo_writer #(.DATA_WIDTH(DW), .WIDTH(BW), .HEIGHT(BH)) u_big (
    .clk(clk), .rst(rst), .data_in(b_din), .valid_in(b_vin), .ready_in(b_rdy),
    .fifo_full(b_full), .wrreq(b_wr), .data_out(b_dout), .frame_done(b_fd)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the unpadded raster surrounded by a one-word ring of zeros.
  function automatic word_q_t pad_frame(input int w, input int h, input word_q_t d);
    word_q_t f;
    for (int r = 0; r < h + 2; r++)
      for (int c = 0; c < w + 2; c++)
        if (r == 0 || r == h + 1 || c == 0 || c == w + 1) f.push_back(DW'(0));
        else f.push_back(d[(r - 1) * w + (c - 1)]);
    return f;
  endfunction

  // FIFO almost-full generator: 0 = off, 1 = held, 2 = random.
  always @(posedge clk) begin
    #1;
    s_full = (s_mode == 2) ? ($urandom_range(0, 2) == 0) : (s_mode == 1);
    b_full = (b_mode == 2) ? ($urandom_range(0, 2) == 0) : (b_mode == 1);
  end

  // Write monitor, mid-cycle; prev_full is what the edge that produced this output saw.
  always @(negedge clk) begin
    cyc++;
    if (s_wr) begin
      check_eq("s_wr_after_full", DW'(s_prev_full), DW'(0));
      s_wq.push_back(s_dout);
      s_wcyc.push_back(cyc);
    end
    if (s_fd) begin
      check_eq("s_fd_with_wr", DW'(s_wr), DW'(1));
      s_fdq.push_back(s_wq.size() - 1);
    end
    if (s_full) check_eq("s_ready_while_full", DW'(s_rdy), DW'(0));
    if (s_rdy) s_rdy_cnt++;
    s_prev_full = s_full;
    if (b_wr) begin
      check_eq("b_wr_after_full", DW'(b_prev_full), DW'(0));
      b_wq.push_back(b_dout);
    end
    if (b_fd) begin
      check_eq("b_fd_with_wr", DW'(b_wr), DW'(1));
      b_fdq.push_back(b_wq.size() - 1);
    end
    if (b_full) check_eq("b_ready_while_full", DW'(b_rdy), DW'(0));
    b_prev_full = b_full;
  end

  task automatic drive(input bit big, input logic v, input logic [DW-1:0] d);
    if (big) begin b_vin = v; b_din = d; end
    else     begin s_vin = v; s_din = d; end
  endtask

  task automatic clear_obs();
    s_wq.delete(); s_fdq.delete(); s_wcyc.delete(); s_rdy_cnt = 0;
    b_wq.delete(); b_fdq.delete();
  endtask

  function automatic word_q_t rand_words(input int n);
    word_q_t q;
    for (int i = 0; i < n; i++) q.push_back(DW'($urandom));
    return q;
  endfunction

  // Source model: presents each word until handshaked; optional bubble before word gap_at.
  task automatic send(input bit big, input word_q_t w, input int gap_at, input int gap_len, input bit rnd);
    for (int i = 0; i < w.size(); i++) begin
      int gap;
      bit acc;
      int k;
      gap = (i == gap_at) ? gap_len : 0;
      if (rnd && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
      if (gap > 0) begin
        drive(big, 1'b0, DW'(0));
        repeat (gap) @(posedge clk);
        #1;
      end
      drive(big, 1'b1, w[i]);
      acc = 1'b0;
      k = 0;
      while (!acc && k < 2000) begin
        @(negedge clk);
        acc = big ? (b_vin && b_rdy) : (s_vin && s_rdy);
        @(posedge clk);
        #1;
        k++;
      end
      if (!acc) begin
        check_eq("accept_timeout", DW'(acc), DW'(1));
        drive(big, 1'b0, DW'(0));
        return;
      end
    end
    drive(big, 1'b0, DW'(0));
  endtask

  task automatic wait_writes(input bit big, input int n);
    int k;
    k = 0;
    while ((big ? b_wq.size() : s_wq.size()) < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic expect_frames(input bit big, input int w, input int h, input word_q_t d, input string tag);
    word_q_t exp, got, chunk, pf;
    int fd[$];
    int fsz, nf;
    fsz = (w + 2) * (h + 2);
    nf  = d.size() / (w * h);
    for (int f = 0; f < nf; f++) begin
      chunk.delete();
      for (int i = 0; i < w * h; i++) chunk.push_back(d[f * w * h + i]);
      pf = pad_frame(w, h, chunk);
      foreach (pf[i]) exp.push_back(pf[i]);
    end
    wait_writes(big, exp.size());
    repeat (5) @(negedge clk);
    if (big) begin got = b_wq; fd = b_fdq; end
    else     begin got = s_wq; fd = s_fdq; end
    check_eq({tag, "_count"}, DW'(got.size()), DW'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), got[i], exp[i]);
    check_eq({tag, "_fd_count"}, DW'(fd.size()), DW'(nf));
    for (int f = 0; f < fd.size() && f < nf; f++)
      check_eq($sformatf("%s_fd%0d_idx", tag, f), DW'(fd[f]), DW'((f + 1) * fsz - 1));
  endtask

  initial begin
    word_q_t words;
    int k;
    rst = 1'b0;
    s_mode = 0;
    b_mode = 0;
    drive(0, 1'b0, DW'(0));
    drive(1, 1'b0, DW'(0));
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wrreq", DW'(s_wr), DW'(0));
    check_eq("rst_data_out", s_dout, DW'(0));
    check_eq("rst_frame_done", DW'(s_fd), DW'(0));
    check_eq("rst_ready_in", DW'(s_rdy), DW'(0));
    check_eq("rst_big_wrreq", DW'(b_wr), DW'(0));
    rst = 1'b1;

    // Clean stream.
    clear_obs();
    words = rand_words(4);
    send(0, words, -1, 0, 1'b0);
    expect_frames(0, SW, SH, words, "t1");
    check_eq("t1_ready_cycles", DW'(s_rdy_cnt), DW'(4));

    // Three-cycle source bubble before the third word.
    clear_obs();
    words = rand_words(4);
    send(0, words, 2, 3, 1'b0);
    expect_frames(0, SW, SH, words, "t2");

    // FIFO almost-full held for 5 cycles once row 1 starts.
    clear_obs();
    words = rand_words(4);
    fork
      send(0, words, -1, 0, 1'b0);
      begin
        wait_writes(0, 5);
        s_mode = 1;
        repeat (5) @(negedge clk);
        s_mode = 0;
      end
    join
    expect_frames(0, SW, SH, words, "t3");

    // Reset mid-frame after the 7th write, then a fresh frame.
    clear_obs();
    words = rand_words(2);
    send(0, words, -1, 0, 1'b0);
    wait_writes(0, 7);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t4_rst_wrreq", DW'(s_wr), DW'(0));
    check_eq("t4_rst_data_out", s_dout, DW'(0));
    check_eq("t4_rst_frame_done", DW'(s_fd), DW'(0));
    check_eq("t4_rst_ready_in", DW'(s_rdy), DW'(0));
    rst = 1'b1;
    clear_obs();
    repeat (5) @(negedge clk);
    check_eq("t4_idle_writes", DW'(s_wq.size()), DW'(0));
    @(posedge clk);
    #1;
    words = rand_words(4);
    send(0, words, -1, 0, 1'b0);
    expect_frames(0, SW, SH, words, "t4");

    // Two frames back-to-back: write stream must be gapless.
    clear_obs();
    words = rand_words(8);
    send(0, words, -1, 0, 1'b0);
    expect_frames(0, SW, SH, words, "t5");
    for (int i = 1; i < s_wcyc.size(); i++)
      check_eq($sformatf("t5_gap%0d", i), DW'(s_wcyc[i] - s_wcyc[i - 1]), DW'(1));

    // Small instance under random valid and back-pressure.
    clear_obs();
    s_mode = 2;
    words = rand_words(12);
    send(0, words, -1, 0, 1'b1);
    expect_frames(0, SW, SH, words, "t6");
    s_mode = 0;

    // Full-size frame under random valid and back-pressure.
    clear_obs();
    b_mode = 2;
    words = rand_words(BW * BH);
    send(1, words, -1, 0, 1'b1);
    expect_frames(1, BW, BH, words, "big");
    b_mode = 0;

    k = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/featuremap_pad_fifo_writer.md
Name: featuremap_pad_fifo_writer

Overview:
- Producer side of the per-channel line-buffer FIFOs that feed the conv2D featuremap filters.
- Accepts one channel's unpadded featuremap stream (WIDTH x HEIGHT fp32 words, raster order) from the previous layer.
- Writes it into one channel FIFO as a zero-padded (WIDTH+2) x (HEIGHT+2) frame, the layout the conv2D line buffers consume.
- Honours FIFO back-pressure and stalls the upstream source while the FIFO cannot accept data.

Parameters:
- DATA_WIDTH, 32: word width (IEEE-754 single precision).
- WIDTH, 56: unpadded featuremap columns.
- HEIGHT, 56: unpadded featuremap rows.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- data_in  input  DATA_WIDTH  unpadded pixel from the upstream layer.
- valid_in  input  1  data_in is valid.
- ready_in  output  1  block accepts data_in this cycle.
- fifo_full  input  1  channel FIFO almost-full flag; asserted with at least one free entry remaining.
- wrreq  output  1  FIFO write enable (registered).
- data_out  output  DATA_WIDTH  FIFO write data (registered).
- frame_done  output  1  one-cycle pulse with the last padded word of a frame.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Outputs: wrreq=0, data_out=0, frame_done=0, ready_in=0.
  - State goes to IDLE; row and column counters clear.
  - Reset mid-frame abandons the frame. No further writes occur until the next frame start.
- Counters:
  - col runs 0..WIDTH+1; row runs 0..HEIGHT+1.
  - Counter width is clog2(WIDTH+2) and clog2(HEIGHT+2) respectively.
- Step: one output word is emitted per cycle in which the state is non-IDLE and fifo_full=0 (sampled). Otherwise the FSM holds all state.
- Emit: a step registers wrreq=1 and data_out for the next cycle. Otherwise wrreq=0 next cycle and data_out holds its value. Output latency is 1 cycle.
- Pad value: 32'h00000000 (+0.0).
- FSM states and transitions:
  - IDLE: ready_in=0; valid_in is not consumed. When valid_in=1, go to TOP with col=0, row=0.
  - TOP: emit a pad word each step. At col=WIDTH+1, wrap col to 0, set row=1, go to LEFT.
  - LEFT: emit one pad word, set col=1, go to DATA.
  - DATA:
    - ready_in = ~fifo_full.
    - A step requires valid_in && ready_in; the accepted word is emitted. If valid_in=0 there is no emission and no advance (bubble).
    - At col=WIDTH, go to RIGHT.
  - RIGHT:
    - Emit one pad word and wrap col to 0.
    - If row=HEIGHT, go to BOTTOM with row=HEIGHT+1; otherwise increment row and go to LEFT.
  - BOTTOM:
    - Emit a pad word each step.
    - At col=WIDTH+1, frame_done=1 alongside that word's wrreq.
    - Then go to IDLE, or go straight to TOP if valid_in=1 in the same cycle (no idle gap between frames).
- ready_in is combinational from state and fifo_full. It is 0 in every state other than DATA.
- Frame size: exactly (WIDTH+2)*(HEIGHT+2) writes, of which WIDTH*HEIGHT are data writes. Data order is preserved bit-exact.
- Simultaneous fifo_full=1 and valid_in=1 in DATA: the word is not accepted (ready_in=0) and the source holds it.
- fifo_full toggling every cycle: writes occur only on cycles following fifo_full=0. No word is lost or duplicated.

Test Plan (WIDTH=2, HEIGHT=2 unless stated):
- Reset then valid_in stream A,B,C,D with fifo_full=0 -> 16 writes: 0,0,0,0, 0,A,B,0, 0,C,D,0, 0,0,0,0. frame_done on the 16th write. ready_in high only in DATA cycles.
- Same stream with valid_in low for 3 cycles before C -> identical write sequence. No writes during the bubble; the 0 after B is written before the bubble.
- fifo_full held 1 for 5 cycles during row 1 -> wrreq=0 from 1 cycle after assertion until 1 cycle after release. ready_in=0 throughout. Sequence unchanged, 16 writes total.
- rst=0 pulse after the 7th write, then a fresh frame E,F,G,H -> outputs 0 the cycle after reset. The next frame is a complete 16-word frame containing E..H only.
- Two frames back-to-back with valid_in=1 at the BOTTOM end -> 32 writes with no wrreq gap. Two frame_done pulses, exactly 16 writes apart.
- Default parameters (56x56), random valid_in/fifo_full -> 3364 writes, 3136 data words in order, and all border words equal 0.
